// File: rtl/rd_fifo_bus_interposer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rd_fifo_bus_interposer_pkg
// Purpose  : Constants shared by the read and write FIFO bus interposers, plus
//            a small helper that counts buffered and in-flight words.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rd_fifo_bus_interposer_pkg;

  localparam int BUS_DATA_WIDTH  = 64;
  localparam int FIFO_WORD_WIDTH = 128;

  // Which half of the held 128-bit word is on the bus
  localparam logic HALF_UPPER = 1'b0;
  localparam logic HALF_LOWER = 1'b1;

  // Number of words the block is responsible for: held in out_reg, held in
  // pf_reg, or already requested from the FIFO. Never exceeds 2 in operation.
  function automatic logic [1:0] word_occupancy(input logic out_valid,
                                                input logic pf_valid,
                                                input logic pend);
    return {1'b0, out_valid} + {1'b0, pf_valid} + {1'b0, pend};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_fifo_bus_interposer.sv
`default_nettype none
// ============================================================================
// Module   : rd_fifo_bus_interposer
// Purpose  : Pulls 128-bit words from a standard-mode (1-cycle latency) read
//            FIFO and presents each as two 64-bit beats, upper half first, to
//            a bus master under a pop handshake. A one-word prefetch buffer
//            keeps one beat per cycle flowing while the FIFO has data.
// Ports    : i_clk               system clock
//            i_rst               asynchronous active-high reset
//            i_rd_fifo_data      FIFO read data, valid the cycle after re
//            o_rd_fifo_re        FIFO read enable
//            i_rd_fifo_empty     FIFO empty flag
//            o_bus_master_data   current 64-bit beat
//            o_bus_master_valid  beat is valid
//            o_bus_master_empty  inverse of o_bus_master_valid
//            i_bus_master_re     bus master pops the current beat
// Revision : 1.0 - initial release
// ============================================================================
module rd_fifo_bus_interposer
  import rd_fifo_bus_interposer_pkg::*;
#(
  // Only 128 is supported
  parameter int RD_FIFO_DATA_WIDTH = FIFO_WORD_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [RD_FIFO_DATA_WIDTH-1:0] i_rd_fifo_data,
  output logic                          o_rd_fifo_re,
  input  logic                          i_rd_fifo_empty,
  output logic [BUS_DATA_WIDTH-1:0]     o_bus_master_data,
  output logic                          o_bus_master_valid,
  output logic                          o_bus_master_empty,
  input  logic                          i_bus_master_re
);

  logic [RD_FIFO_DATA_WIDTH-1:0] out_reg;
  logic                          out_valid;
  logic                          half;
  logic [RD_FIFO_DATA_WIDTH-1:0] pf_reg;
  logic                          pf_valid;
  logic                          pend;

  logic [1:0] occupancy;
  logic       pop;
  logic       out_free;
  logic       park_in_pf;

  always_comb begin
    occupancy    = word_occupancy(out_valid, pf_valid, pend);
    // Gate with reset so the FIFO never sees a read while this block is held
    o_rd_fifo_re = ~i_rd_fifo_empty & ~i_rst & (occupancy < 2'd2);
    pop          = i_bus_master_re & out_valid;
    // out_reg can accept a word if empty or if its last beat leaves now
    out_free     = ~out_valid | (pop & (half == HALF_LOWER));
    // Returning data goes to the prefetch slot unless it loads out_reg
    // directly; by the occupancy bound pf_reg is always empty when this fires
    // with out_reg still occupied.
    park_in_pf   = pend & ~(out_free & ~pf_valid);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_reg   <= '0;
      out_valid <= 1'b0;
      half      <= HALF_UPPER;
      pf_reg    <= '0;
      pf_valid  <= 1'b0;
      pend      <= 1'b0;
    end else begin
      pend <= o_rd_fifo_re;

      if (out_free) begin
        if (pf_valid) begin
          out_reg   <= pf_reg;
          out_valid <= 1'b1;
          half      <= HALF_UPPER;
        end else if (pend) begin
          out_reg   <= i_rd_fifo_data;
          out_valid <= 1'b1;
          half      <= HALF_UPPER;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (pop) begin
        half <= HALF_LOWER;
      end

      if (park_in_pf) begin
        pf_reg   <= i_rd_fifo_data;
        pf_valid <= 1'b1;
      end else if (out_free && pf_valid) begin
        pf_valid <= 1'b0;
      end
    end
  end

  assign o_bus_master_data  = (half == HALF_LOWER) ? out_reg[BUS_DATA_WIDTH-1:0]
                                                   : out_reg[RD_FIFO_DATA_WIDTH-1 -: BUS_DATA_WIDTH];
  assign o_bus_master_valid = out_valid;
  assign o_bus_master_empty = ~out_valid;

endmodule
`default_nettype wire

// File: tb/tb_rd_fifo_bus_interposer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_fifo_bus_interposer
// Purpose  : Self-checking bench. A FIFO model feeds the interposer; a beat
//            queue model predicts valid/data/re every cycle, and directed
//            scenarios pin exact cycle-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_fifo_bus_interposer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] fifo_data = '0;
  logic         fifo_empty = 1'b1;
  logic         pop_req = 1'b0;
  logic         re;
  logic         valid;
  logic         bempty;
  logic [63:0]  bdata;

  rd_fifo_bus_interposer #(.RD_FIFO_DATA_WIDTH(128)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_rd_fifo_data     (fifo_data),
    .o_rd_fifo_re       (re),
    .i_rd_fifo_empty    (fifo_empty),
    .o_bus_master_data  (bdata),
    .o_bus_master_valid (valid),
    .o_bus_master_empty (bempty),
    .i_bus_master_re    (pop_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and the ordered beats that have entered the interposer but
  // not yet been popped. A word's beats enter at the edge its data returns.
  logic [127:0] fifo_q[$];
  logic [63:0]  avail[$];
  bit           inflight = 1'b0;
  bit           chk_en = 1'b0;
  bit           re_s;
  bit           pop_s;
  int           cmp_words;
  bit           cmp_re;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the beat-queue model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      cmp_words = (avail.size() + 1) / 2;
      cmp_re    = !fifo_empty && ((cmp_words + int'(inflight)) < 2);
      check("rd_fifo_re", re, cmp_re);
      check("bus_valid", valid, avail.size() > 0);
      check("bus_empty", bempty, avail.size() == 0);
      if (avail.size() > 0) check("bus_data", bdata, avail[0]);
      check("occupancy_le_2", ((cmp_words + int'(inflight)) <= 2), 1'b1);
    end
  end

  task automatic push_word(input logic [127:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample handshakes at negedge, then update models after posedge
  task automatic tick();
    @(negedge clk);
    re_s  = re;
    pop_s = pop_req && valid;
    @(posedge clk);
    #1;
    if (pop_s && avail.size() > 0) void'(avail.pop_front());
    if (inflight) begin
      avail.push_back(fifo_data[127:64]);
      avail.push_back(fifo_data[63:0]);
    end
    inflight = re_s;
    if (re_s) begin
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow: actual re=1 required re=0 at %0t", $time);
      end else begin
        fifo_data = fifo_q.pop_front();
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    pop_req = 1'b1;
    while ((fifo_q.size() > 0 || avail.size() > 0 || inflight) && n < 200) begin
      tick();
      n++;
    end
    check(name, (fifo_q.size() == 0 && avail.size() == 0 && !inflight), 1'b1);
    pop_req = 1'b0;
    tick();
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] w1;
    logic [127:0] ws[4];
    logic [127:0] wr;
    int           n;
    int           re_cnt;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fifo_empty = 1'b0;
    #1;
    check("reset_valid", valid, 1'b0);
    check("reset_empty", bempty, 1'b1);
    check("reset_data", bdata, 64'h0);
    check("reset_re", re, 1'b0);
    fifo_empty = 1'b1;
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();

    // ---------------- single word, slow consumer ----------------
    w1 = 128'h1111111111111111_2222222222222222;
    push_word(w1);
    #1 check("t1_c0_re", re, 1'b1);
    tick(); #1;
    check("t1_c1_re", re, 1'b0);
    check("t1_c1_valid", valid, 1'b0);
    tick(); #1;
    check("t1_c2_valid", valid, 1'b1);
    check("t1_c2_data", bdata, 64'h1111111111111111);
    tick(); tick(); tick();
    pop_req = 1'b1;
    #1 check("t1_c5_data", bdata, 64'h1111111111111111);
    tick(); #1;
    check("t1_c6_valid", valid, 1'b1);
    check("t1_c6_data", bdata, 64'h2222222222222222);
    tick(); #1;
    check("t1_c7_valid", valid, 1'b0);
    // pop held while invalid must not be remembered
    tick(); tick();
    pop_req = 1'b0;

    // ---------------- empty FIFO, pop pulsed ----------------
    for (int i = 0; i < 6; i++) begin
      pop_req = i[0];
      #1;
      check("empty_re", re, 1'b0);
      check("empty_valid", valid, 1'b0);
      tick();
    end
    pop_req = 1'b0;
    w1 = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
    push_word(w1);
    tick(); tick(); #1;
    check("empty_after_valid", valid, 1'b1);
    check("empty_after_upper", bdata, 64'hA5A5A5A50F0F0F0F);
    drain("empty_drain");

    // ---------------- streaming 4 words ----------------
    for (int k = 0; k < 4; k++) begin
      ws[k] = rand_word();
      push_word(ws[k]);
    end
    pop_req = 1'b1;
    n = 0;
    while (!valid && n < 6) begin
      tick(); #1;
      n++;
    end
    check("stream_first_valid", valid, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("stream_gapless", valid, 1'b1);
      check("stream_beat", bdata, (i % 2 == 0) ? ws[i/2][127:64] : ws[i/2][63:0]);
      tick(); #1;
    end
    check("stream_done_valid", valid, 1'b0);
    pop_req = 1'b0;
    tick();

    // ---------------- backpressure ----------------
    for (int k = 0; k < 5; k++) push_word(rand_word());
    re_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (re) re_cnt++;
      tick();
    end
    check("backpressure_reads", re_cnt, 2);
    pop_req = 1'b1;
    n = 0;
    #1;
    while (!re && n < 6) begin
      tick(); #1;
      n++;
    end
    check("backpressure_resume_re", re, 1'b1);
    drain("backpressure_drain");

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 3000; c++) begin
      pop_req = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 25 && fifo_q.size() < 6) push_word(rand_word());
      tick();
    end
    drain("random_drain");

    // ---------------- reset mid-stream ----------------
    for (int k = 0; k < 3; k++) push_word(rand_word());
    pop_req = 1'b1;
    n = 0;
    while (!(valid && (avail.size() % 2 == 1)) && n < 10) begin
      tick();
      n++;
    end
    check("rst_reach_lower", (valid && (avail.size() % 2 == 1)), 1'b1);
    #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", valid, 1'b0);
    check("rst_mid_empty", bempty, 1'b1);
    check("rst_mid_data", bdata, 64'h0);
    check("rst_mid_re", re, 1'b0);
    avail.delete();
    fifo_q.delete();
    inflight = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    pop_req = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    wr = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
    push_word(wr);
    n = 0;
    #1;
    while (!valid && n < 6) begin
      tick(); #1;
      n++;
    end
    check("rst_after_valid", valid, 1'b1);
    check("rst_after_upper", bdata, 64'hCAFEBABEDEADBEEF);
    pop_req = 1'b1;
    tick(); #1;
    check("rst_after_lower", bdata, 64'h0123456789ABCDEF);
    drain("rst_drain");

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rd_fifo_bus_interposer.md
# rd_fifo_bus_interposer

Read-side counterpart of the write FIFO bus interposer. Pulls 128-bit words from the flash controller's read FIFO, which is standard mode with 1-cycle read latency. Presents each word to the 64-bit bus master as two consecutive 64-bit beats under a pop handshake: upper half [127:64] first, then lower half [63:0]. A one-word prefetch buffer sustains one beat per cycle while the FIFO has data.

## Interface
- RD_FIFO_DATA_WIDTH, 128, read FIFO word width; only 128 is supported.
- Reset: one clock; reset is asynchronous and active-high.
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_rd_fifo_data  in  RD_FIFO_DATA_WIDTH  FIFO read data, valid the cycle after o_rd_fifo_re
- o_rd_fifo_re  out  1  FIFO read enable
- i_rd_fifo_empty  in  1  FIFO empty flag
- o_bus_master_data  out  64  current beat
- o_bus_master_valid  out  1  beat on o_bus_master_data is valid
- o_bus_master_empty  out  1  equals ~o_bus_master_valid
- i_bus_master_re  in  1  bus master pops current beat

## Operation
- State registers:
  - out_reg[127:0], out_valid, half (0 = upper beat, 1 = lower beat)
  - pf_reg[127:0], pf_valid
  - pend: registered o_rd_fifo_re, meaning a read is in flight
- Read issue:
  - o_rd_fifo_re = ~i_rd_fifo_empty & ~i_rst & ((out_valid + pf_valid + pend) < 2).
  - The count uses registered values only; pops in the same cycle are ignored.
  - Total of held plus in-flight words therefore never exceeds 2.
- Pop: pop = i_bus_master_re & out_valid.
  - A pop with out_valid=0 is ignored.
  - Pop with half=0 sets half=1.
  - Pop with half=1 frees out_reg.
- out_reg load priority when out_reg is empty or being freed this cycle:
  1. pf_reg, if pf_valid (pf_valid clears).
  2. Else i_rd_fifo_data, if pend.
  3. Else out_valid=0.
  - Any load sets half=0.
- When pend=1 and out_reg is not free (or pf_reg feeds it), returning data goes to pf_reg and sets pf_valid.
- Invariant: pend and pf_valid are never 1 together at data return with out_reg occupied. Returning data is never dropped.
- o_bus_master_data = half ? out_reg[63:0] : out_reg[127:64].
- Reset values: all registers 0.
  - o_bus_master_valid=0, o_bus_master_empty=1, o_bus_master_data=0, o_rd_fifo_re=0.
- Reset mid-operation: held words and any in-flight FIFO word are discarded. The FIFO is reset alongside this block.

## Timing
- First-beat latency from an empty block with a non-empty FIFO:
  - cycle 0: re=1
  - cycle 1: data registered into out_reg
  - cycle 2: o_bus_master_valid=1, upper half presented
- Throughput: one beat per cycle sustained with continuous pops and a non-empty FIFO. No bubble between words: pf_reg transfers on the lower-half pop.
- Beat order per word: [127:64], then [63:0]. This exactly inverts the write interposer's packing.
- Outputs come from registers through a 2:1 mux. The only combinational path is to o_rd_fifo_re, from i_rd_fifo_empty.
- i_bus_master_re held high with valid=0 has no effect and is not remembered.
- FIFO going empty while pend=1: the in-flight word is still captured.

## Structure
- Shared package constants:
  - BUS_DATA_WIDTH=64
  - FIFO_WORD_WIDTH=128
  - HALF_UPPER=0, HALF_LOWER=1
  - These are shared with the write interposer.
- Single flat module with no sub-module. The two-entry word buffer is small enough to stay inline.

## Test plan
- Single word, slow consumer:
  - Stimulus: FIFO holds 0x1111..._2222... (upper 0x1111111111111111, lower 0x2222222222222222); pop high from cycle 5.
  - Response: re in cycle 0 only; valid from cycle 2 showing 0x1111111111111111; after first pop 0x2222222222222222; after second pop valid=0.
- Streaming:
  - Stimulus: 4 words in FIFO; pop held high.
  - Response: 8 consecutive valid beats with no gap, in upper/lower order; at most 2 words held plus in flight at any cycle.
- Backpressure:
  - Stimulus: pop low with FIFO non-empty.
  - Response: exactly 2 reads issued, then re=0 until a word is freed.
- Empty FIFO:
  - Stimulus: i_rd_fifo_empty=1; pop pulsed.
  - Response: re=0, valid=0, state unchanged.
- FIFO empties with a read in flight:
  - Stimulus: empty rises the cycle after re.
  - Response: the in-flight word is still delivered as 2 beats.
- Reset mid-stream:
  - Stimulus: assert i_rst asynchronously between the upper and lower beat.
  - Response: valid=0, empty=1, data=0, re=0 immediately; after release, the next FIFO word is delivered starting with its upper half.
